// File: rtl/serial_readout_sequencer.sv
// Serial-out mux with automatic channel scan for PSEC5 readout.
// Define SCAN_HEADER_EN to prefix each channel frame with an 8-bit header.
module serial_readout_sequencer #(
   parameter int N_CH       = 8,
   parameter int FRAME_BITS = 50
) (
   input  logic                      sclk,
   input  logic                      rstn,
   input  logic [N_CH-1:0]           raw_serial_out,
   input  logic                      wr_serial_out,
   input  logic [7:0]                mux_control_signal,
   input  logic [N_CH-1:0]           scan_mask,
   input  logic                      scan_start,
   output logic [N_CH-1:0]           load_cnt_ser,
   output logic                      serial_out,
   output logic                      scan_busy,
   output logic                      scan_done,
   output logic [$clog2(N_CH)-1:0]   cur_ch
);

   localparam int CW = $clog2(N_CH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      SHIFT  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state_q;
   logic [N_CH-1:0] mask_q;
   logic [CW-1:0]   cur_q;
   logic [7:0]      bit_cnt_q;
   logic [N_CH-1:0] load_q;
   logic            serial_q;
   logic            busy_q;
   logic            done_q;
   logic            man_bit;
   logic [CW:0]     first_d;
   logic [CW:0]     next_d;
   logic [6:0]      sel;
   logic            scan_en;

`ifdef SCAN_HEADER_EN
   logic [2:0]      hdr_cnt_q;
   logic [7:0]      hdr_word;
   assign hdr_word = {4'b1010, 4'(cur_q)};
`endif

   // {found, index} of the lowest set bit of m at or above from
   function automatic logic [CW:0] find_next(
      input logic [N_CH-1:0] m,
      input logic [CW:0]     from
   );
      logic [CW:0] r;
      r = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (m[i] && ((CW+1)'(i) >= from))
            r = {1'b1, CW'(i)};
      return r;
   endfunction

   function automatic logic [N_CH-1:0] onehot(input logic [CW-1:0] c);
      return N_CH'(1) << c;
   endfunction

   assign sel     = mux_control_signal[6:0];
   assign scan_en = mux_control_signal[7];
   assign first_d = find_next(scan_mask, '0);
   assign next_d  = find_next(mask_q, {1'b0, cur_q} + (CW+1)'(1));

   always_comb begin
      man_bit = 1'b0;
      if (sel == 7'd0)
         man_bit = wr_serial_out;
      for (int i = 0; i < N_CH; i++)
         if (sel == 7'(i + 1))
            man_bit = raw_serial_out[i];
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         cur_q     <= '0;
         bit_cnt_q <= '0;
         load_q    <= '0;
         serial_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SCAN_HEADER_EN
         hdr_cnt_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               serial_q <= man_bit;
               load_q   <= '0;
               busy_q   <= 1'b0;
               if (scan_start && scan_en) begin
                  mask_q    <= scan_mask;
                  bit_cnt_q <= '0;
                  if (first_d[CW]) begin
                     cur_q  <= first_d[CW-1:0];
                     busy_q <= 1'b1;
`ifdef SCAN_HEADER_EN
                     hdr_cnt_q <= '0;
                     state_q   <= HEADER;
`else
                     load_q  <= onehot(first_d[CW-1:0]);
                     state_q <= SHIFT;
`endif
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
`ifdef SCAN_HEADER_EN
            HEADER: begin
               if (!scan_en) begin
                  state_q   <= IDLE;
                  load_q    <= '0;
                  busy_q    <= 1'b0;
                  serial_q  <= 1'b0;
                  bit_cnt_q <= '0;
               end else begin
                  serial_q  <= hdr_word[3'd7 - hdr_cnt_q];
                  hdr_cnt_q <= hdr_cnt_q + 3'd1;
                  if (hdr_cnt_q == 3'd7) begin
                     load_q  <= onehot(cur_q);
                     state_q <= SHIFT;
                  end
               end
            end
`endif
            SHIFT: begin
               if (!scan_en) begin
                  state_q   <= IDLE;
                  load_q    <= '0;
                  busy_q    <= 1'b0;
                  serial_q  <= 1'b0;
                  bit_cnt_q <= '0;
               end else begin
                  serial_q  <= raw_serial_out[cur_q];
                  bit_cnt_q <= bit_cnt_q + 8'd1;
                  if (bit_cnt_q == 8'(FRAME_BITS - 1)) begin
                     bit_cnt_q <= '0;
                     if (next_d[CW]) begin
                        cur_q <= next_d[CW-1:0];
`ifdef SCAN_HEADER_EN
                        load_q    <= '0;
                        hdr_cnt_q <= '0;
                        state_q   <= HEADER;
`else
                        load_q <= onehot(next_d[CW-1:0]);
`endif
                     end else begin
                        load_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               serial_q <= 1'b0;
               load_q   <= '0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign load_cnt_ser = load_q;
   assign serial_out   = serial_q;
   assign scan_busy    = busy_q;
   assign scan_done    = done_q;
   assign cur_ch       = cur_q;

endmodule

// File: tb/tb_serial_readout_sequencer.sv
// Directed bench for serial_readout_sequencer: manual mux, scans,
// abort and reset, with a queue of expected serial bits.
`timescale 1ns/1ps
module tb_serial_readout_sequencer;

   localparam int N_CH = 8;
   localparam int FB   = 50;
`ifdef SCAN_HEADER_EN
   localparam int HDR = 8;
`else
   localparam int HDR = 0;
`endif

   logic            sclk = 1'b0;
   logic            rstn = 1'b0;
   logic [N_CH-1:0] raw_serial_out = '0;
   logic            wr_serial_out = 1'b0;
   logic [7:0]      mux_control_signal = '0;
   logic [N_CH-1:0] scan_mask = '0;
   logic            scan_start = 1'b0;
   logic [N_CH-1:0] load_cnt_ser;
   logic            serial_out;
   logic            scan_busy;
   logic            scan_done;
   logic [2:0]      cur_ch;

   serial_readout_sequencer #(.N_CH(N_CH), .FRAME_BITS(FB)) dut (
      .sclk               (sclk),
      .rstn               (rstn),
      .raw_serial_out     (raw_serial_out),
      .wr_serial_out      (wr_serial_out),
      .mux_control_signal (mux_control_signal),
      .scan_mask          (scan_mask),
      .scan_start         (scan_start),
      .load_cnt_ser       (load_cnt_ser),
      .serial_out         (serial_out),
      .scan_busy          (scan_busy),
      .scan_done          (scan_done),
      .cur_ch             (cur_ch)
   );

   always #5 sclk = ~sclk;

   typedef struct packed {
      logic [3:0] ch;
      logic       hdr;
      logic       hbit;
   } slot_t;

   int    n_cmp = 0;
   int    n_err = 0;
   logic  exp_q[$];
   slot_t sched[$];

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge sclk);
      #1;
   endtask

   task automatic man(input logic [7:0] sel, input int n);
      int   s;
      logic e;
      mux_control_signal = sel;
      s = int'(sel[6:0]);
      for (int i = 0; i < n; i++) begin
         wr_serial_out  = i[0];
         raw_serial_out = N_CH'($urandom);
         if (s == 0)
            e = wr_serial_out;
         else if (s <= N_CH)
            e = raw_serial_out[s-1];
         else
            e = 1'b0;
         exp_q.push_back(e);
         tick;
         chk("man_serial", 16'(serial_out), 16'(exp_q.pop_front()));
         chk("man_load", 16'(load_cnt_ser), 16'd0);
      end
   endtask

   task automatic run_scan(input logic [7:0] mask, input int abort_at);
      logic [7:0] hw;
      slot_t      sl;
      sched.delete();
      exp_q.delete();
      for (int c = 0; c < N_CH; c++) begin
         if (mask[c]) begin
            hw = {4'b1010, 4'(c)};
            for (int h = 0; h < HDR; h++)
               sched.push_back('{ch: 4'(c), hdr: 1'b1, hbit: hw[7-h]});
            for (int b = 0; b < FB; b++)
               sched.push_back('{ch: 4'(c), hdr: 1'b0, hbit: 1'b0});
         end
      end
      mux_control_signal = 8'h80;
      scan_mask  = mask;
      scan_start = 1'b1;
      tick;
      scan_start = 1'b0;
      scan_mask  = ~mask;
      for (int j = 0; j < sched.size(); j++) begin
         sl = sched[j];
         if (j == abort_at) begin
            mux_control_signal = 8'h00;
            tick;
            chk("abort_load", 16'(load_cnt_ser), 16'd0);
            chk("abort_busy", 16'(scan_busy), 16'd0);
            chk("abort_done", 16'(scan_done), 16'd0);
            for (int k = 0; k < 10; k++) begin
               tick;
               chk("post_abort_done", 16'(scan_done), 16'd0);
               chk("post_abort_load", 16'(load_cnt_ser), 16'd0);
            end
            exp_q.delete();
            return;
         end
         chk("scan_load", 16'(load_cnt_ser),
             sl.hdr ? 16'd0 : (16'd1 << sl.ch));
         chk("scan_busy", 16'(scan_busy), 16'd1);
         chk("scan_cur", 16'(cur_ch), 16'(sl.ch));
         chk("scan_done_early", 16'(scan_done), 16'd0);
         if (exp_q.size() > 0)
            chk("scan_serial", 16'(serial_out), 16'(exp_q.pop_front()));
         raw_serial_out = N_CH'($urandom);
         exp_q.push_back(sl.hdr ? sl.hbit : raw_serial_out[sl.ch]);
         tick;
      end
      chk("done_pulse", 16'(scan_done), 16'd1);
      chk("done_load", 16'(load_cnt_ser), 16'd0);
      chk("done_busy", 16'(scan_busy), 16'd0);
      if (exp_q.size() > 0)
         chk("last_serial", 16'(serial_out), 16'(exp_q.pop_front()));
      tick;
      chk("done_single", 16'(scan_done), 16'd0);
      chk("idle_busy", 16'(scan_busy), 16'd0);
   endtask

   initial begin
      rstn = 1'b0;
      repeat (2) tick;
      chk("rst_load", 16'(load_cnt_ser), 16'd0);
      chk("rst_serial", 16'(serial_out), 16'd0);
      chk("rst_busy", 16'(scan_busy), 16'd0);
      chk("rst_done", 16'(scan_done), 16'd0);
      chk("rst_cur", 16'(cur_ch), 16'd0);
      rstn = 1'b1;
      tick;

      man(8'h00, 8);
      man(8'h03, 8);
      man(8'h08, 8);
      man(8'h01, 6);
      man(8'h09, 6);
      man(8'h7F, 6);

      run_scan(8'hFF, -1);
      run_scan(8'h24, -1);
      run_scan(8'h00, -1);
      run_scan(8'hFF, 3 * (HDR + FB) + HDR + 20);
      run_scan(8'h20, -1);

      // reset in the middle of a scan
      mux_control_signal = 8'h80;
      scan_mask  = 8'h24;
      scan_start = 1'b1;
      tick;
      scan_start = 1'b0;
      repeat (30) tick;
      chk("pre_rst_busy", 16'(scan_busy), 16'd1);
      rstn = 1'b0;
      #1;
      chk("arst_load", 16'(load_cnt_ser), 16'd0);
      chk("arst_serial", 16'(serial_out), 16'd0);
      chk("arst_busy", 16'(scan_busy), 16'd0);
      chk("arst_done", 16'(scan_done), 16'd0);
      chk("arst_cur", 16'(cur_ch), 16'd0);
      tick;
      rstn = 1'b1;
      tick;
      run_scan(8'h24, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
